button_capture_responder: RTL and testbench

// Avalon-MM responder that the Nios II reads to sample the DE10-Lite push buttons.

---
 rtl/button_capture_responder_if.sv | 28 ++
 rtl/button_capture_responder.sv | 138 +++++++++++++
 tb/tb_button_capture_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/button_capture_responder_if.sv
// Avalon-MM slave bus bundle for the push-button capture responder.
// The interconnect side uses the master modport, the responder the slave modport.
interface button_capture_responder_if;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_chipselect,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_chipselect,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/button_capture_responder.sv
// Push-button responder: 2-FF synchroniser, per-bit debounce counter,
// press-edge capture into a write-1-to-clear register, maskable level irq.
// Read data is registered with a fixed latency of one cycle.
module button_capture_responder #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CAPTURE_FALLING = 1
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [WIDTH-1:0]              button_in,
    button_capture_responder_if.slave     avs,
    output logic                          irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // synchroniser, debounce and edge state
    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] deb_r;
    logic [WIDTH-1:0] deb_prev_r;
    logic [CNT_W-1:0] cnt_r [WIDTH];
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edge_r;
    logic [31:0]      readdata_r;
    logic             irq_r;

    // next-state signals
    logic [WIDTH-1:0] deb_next_s;
    logic [CNT_W-1:0] cnt_next_s [WIDTH];
    logic [WIDTH-1:0] edge_set_s;
    logic [WIDTH-1:0] edge_clr_s;
    logic [WIDTH-1:0] edge_next_s;
    logic [WIDTH-1:0] mask_next_s;
    logic [WIDTH-1:0] data_view_s;
    logic [31:0]      rd_mux_s;
    logic             rd_s;
    logic             wr_s;
    logic             wdata_unused_s;

    assign rd_s = avs.avs_chipselect & avs.avs_read;
    assign wr_s = avs.avs_chipselect & avs.avs_write;

    // Upper write-data bits beyond WIDTH carry no meaning for this block.
    assign wdata_unused_s = ^avs.avs_writedata;

    // Debounce: count while the synchronised level disagrees, accept at terminal count.
    always_comb begin
        deb_next_s = deb_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next_s[i] = '0;
            if (sync2_r[i] != deb_r[i]) begin
                if (cnt_r[i] == CNT_MAX) begin
                    deb_next_s[i] = sync2_r[i];
                    cnt_next_s[i] = '0;
                end else begin
                    cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
                end
            end else begin
                cnt_next_s[i] = '0;
            end
        end
    end

    // Edge capture and bus-side register updates; a set beats a same-cycle clear.
    always_comb begin
        edge_set_s  = '0;
        edge_clr_s  = '0;
        mask_next_s = mask_r;
        data_view_s = deb_r;
        if (CAPTURE_FALLING != 0) begin
            edge_set_s  = deb_prev_r & ~deb_r;
            data_view_s = ~deb_r;
        end else begin
            edge_set_s  = ~deb_prev_r & deb_r;
            data_view_s = deb_r;
        end
        if (wr_s && (avs.avs_address == 2'd1)) begin
            mask_next_s = avs.avs_writedata[WIDTH-1:0];
        end else begin
            mask_next_s = mask_r;
        end
        if (wr_s && (avs.avs_address == 2'd3)) begin
            edge_clr_s = avs.avs_writedata[WIDTH-1:0];
        end else begin
            edge_clr_s = '0;
        end
        edge_next_s = (edge_r & ~edge_clr_s) | edge_set_s;
    end

    // Read mux over current register values; unused bits and address 2 read zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (avs.avs_address)
            2'd0:    rd_mux_s[WIDTH-1:0] = data_view_s;
            2'd1:    rd_mux_s[WIDTH-1:0] = mask_r;
            2'd2:    rd_mux_s = 32'd0;
            2'd3:    rd_mux_s[WIDTH-1:0] = edge_r;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // State registers; reset parks inputs at the released (high) level so no edge is seen.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_r    <= '1;
            sync2_r    <= '1;
            deb_r      <= '1;
            deb_prev_r <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= '0;
            end
            mask_r     <= '0;
            edge_r     <= '0;
            readdata_r <= 32'd0;
            irq_r      <= 1'b0;
        end else begin
            sync1_r    <= button_in;
            sync2_r    <= sync1_r;
            deb_r      <= deb_next_s;
            deb_prev_r <= deb_r;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
            mask_r     <= mask_next_s;
            edge_r     <= edge_next_s;
            readdata_r <= rd_s ? rd_mux_s : 32'd0;
            // Tracks |(edge & mask) of the registers themselves, but from a flop.
            irq_r      <= |(edge_next_s & mask_next_s);
        end
    end

    assign avs.avs_readdata = readdata_r;
    assign irq              = irq_r;

endmodule

// File: tb/tb_button_capture_responder.sv
// Directed bench for button_capture_responder (WIDTH=2, DEBOUNCE_CYCLES=8,
// CAPTURE_FALLING=1). Reads push their expected data into a queue; a monitor
// pops and compares one cycle later and checks readdata is 0 otherwise.
module tb_button_capture_responder;

    logic       clk = 1'b0;
    logic       reset_reset;
    logic [1:0] button_in;
    logic       irq;

    always #5 clk = ~clk;

    button_capture_responder_if bus ();

    button_capture_responder #(
        .WIDTH(2),
        .DEBOUNCE_CYCLES(8),
        .CAPTURE_FALLING(1)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (reset_reset),
        .button_in   (button_in),
        .avs         (bus),
        .irq         (irq)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];
    logic        rd_d   = 1'b0;
    bit          mon_en = 1'b0;

    // remember whether a read was presented at the last edge
    always @(posedge clk) rd_d <= bus.avs_chipselect & bus.avs_read;

    // monitor: compare read data against the scoreboard, idle data against 0
    always @(negedge clk) begin
        logic [31:0] exp;
        if (mon_en) begin
            checks++;
            if (rd_d) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_unexpected: readdata=%h with no expected entry", bus.avs_readdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.avs_readdata !== exp) begin
                        errors++;
                        $display("FAIL read_data: got %h expected %h at %0t", bus.avs_readdata, exp, $time);
                    end
                end
            end else if (bus.avs_readdata !== 32'd0) begin
                errors++;
                $display("FAIL idle_readdata: got %h expected 00000000 at %0t", bus.avs_readdata, $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input logic [1:0] a, input bit rd, input bit wr,
                          input logic [31:0] wd, input logic [31:0] exp);
        bus.avs_chipselect = 1'b1;
        bus.avs_read       = rd;
        bus.avs_write      = wr;
        bus.avs_address    = a;
        bus.avs_writedata  = wd;
        if (rd) exp_q.push_back(exp);
        tick(1);
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_writedata  = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        bus_op(a, 1'b1, 1'b0, 32'd0, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_op(a, 1'b0, 1'b1, d, 32'd0);
    endtask

    task automatic check_irq(input string name, input logic exp);
        checks++;
        if (irq !== exp) begin
            errors++;
            $display("FAIL %s: irq=%b expected %b at %0t", name, irq, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_reset        = 1'b1;
        button_in          = 2'b11;
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_address    = 2'd0;
        bus.avs_writedata  = 32'd0;
        tick(3);
        reset_reset = 1'b0;
        mon_en      = 1'b1;

        // 1. reset state
        check_irq("reset_irq", 1'b0);
        rd(2'd0, 32'd0);
        rd(2'd1, 32'd0);
        rd(2'd2, 32'd0);
        rd(2'd3, 32'd0);
        check_irq("reset_irq_after_reads", 1'b0);
        wr(2'd1, 32'h1);
        rd(2'd1, 32'h1);

        // 2. bounces of 5 and 7 cycles never reach the debounced state
        button_in[0] = 1'b0; tick(5);
        button_in[0] = 1'b1; tick(12);
        button_in[0] = 1'b0; tick(7);
        button_in[0] = 1'b1; tick(12);
        rd(2'd0, 32'd0);
        rd(2'd3, 32'd0);
        check_irq("bounce_irq", 1'b0);

        // 3. held press: deb falls 10 edges later, edge and irq one edge after that
        button_in[0] = 1'b0;
        tick(10);
        check_irq("press_irq_early", 1'b0);
        tick(1);
        check_irq("press_irq_rise", 1'b1);
        rd(2'd0, 32'h1);
        rd(2'd3, 32'h1);

        // 4. clearing the wrong bit keeps the edge; clearing bit 0 drops irq
        wr(2'd3, 32'h2);
        check_irq("clear_other_bit_irq", 1'b1);
        rd(2'd3, 32'h1);
        wr(2'd3, 32'h1);
        check_irq("clear_irq_fall", 1'b0);
        rd(2'd3, 32'h0);

        // 5. set and clear of bit 1 in the same cycle: set wins
        wr(2'd1, 32'h2);
        rd(2'd1, 32'h2);
        button_in[1] = 1'b0;
        tick(10);
        bus_op(2'd3, 1'b1, 1'b1, 32'h2, 32'h0);
        check_irq("set_wins_irq", 1'b1);
        rd(2'd3, 32'h2);
        rd(2'd0, 32'h3);
        // read and clear together: read returns pre-clear value
        bus_op(2'd3, 1'b1, 1'b1, 32'h2, 32'h2);
        check_irq("rw_clear_irq", 1'b0);
        rd(2'd3, 32'h0);
        // ignored writes and upper bits
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd0, 32'h3);
        rd(2'd2, 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'h3);
        wr(2'd1, 32'h0);

        // releases (rising edges) are not captured
        button_in = 2'b11;
        tick(12);
        rd(2'd0, 32'h0);
        rd(2'd3, 32'h0);
        check_irq("release_irq", 1'b0);

        // 6. reset four cycles into a debounce; count must rerun in full
        button_in[0] = 1'b0;
        tick(4);
        reset_reset = 1'b1;
        tick(1);
        reset_reset = 1'b0;
        rd(2'd1, 32'h0);
        rd(2'd3, 32'h0);
        wr(2'd1, 32'h1);
        tick(6);
        check_irq("rerun_irq_10", 1'b0);
        tick(1);
        check_irq("rerun_irq_11", 1'b0);
        tick(1);
        check_irq("rerun_irq_12", 1'b1);
        rd(2'd3, 32'h1);
        rd(2'd0, 32'h1);

        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d reads still outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
